// File: rtl/seq_div32.sv
// seq_div32: sequential 32-bit signed restoring divider returning {remainder, quotient}.
// Optional DIV_ZERO_TRAP_EN: zero divisor skips iteration and flags div_zero.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] prem, qreg, dvs, dvd_mag, dvs_mag;
    logic [WIDTH:0]   shifted, diff;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, zero_trap;

`ifdef DIV_ZERO_TRAP_EN
    logic dz;
    assign zero_trap = (divisor == '0);
`else
    assign zero_trap = 1'b0;
    assign div_zero  = 1'b0;
`endif

    assign busy   = (state != IDLE);
    assign result = {remainder, quotient};

    always_comb begin
        dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag  = divisor[WIDTH-1] ? -divisor : divisor;
        shifted  = {prem, qreg[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        state_nx = (state == IDLE) ? (start ? (zero_trap ? FIX : CALC) : IDLE) :
                   (state == CALC) ? ((cnt == LAST) ? FIX : CALC) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            prem      <= '0;
            qreg      <= '0;
            dvs       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            dz        <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= (state == FIX);
            if (state == IDLE && start) begin
                // A trapped zero divisor preloads the remainder path so FIX rebuilds the dividend.
                prem  <= zero_trap ? dvd_mag : '0;
                qreg  <= zero_trap ? '1 : dvd_mag;
                q_neg <= zero_trap ? 1'b0 : dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg <= dividend[WIDTH-1];
                dvs   <= dvs_mag;
                cnt   <= '0;
`ifdef DIV_ZERO_TRAP_EN
                dz    <= zero_trap;
`endif
            end else if (state == CALC) begin
                prem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                qreg <= {qreg[WIDTH-2:0], ~diff[WIDTH]};
                cnt  <= cnt + 1'b1;
            end else if (state == FIX) begin
                quotient  <= q_neg ? -qreg : qreg;
                remainder <= r_neg ? -prem : prem;
`ifdef DIV_ZERO_TRAP_EN
                div_zero  <= dz;
`endif
            end
        end
    end
endmodule

// File: doc/seq_div32.md
# seq_div32

Sequential 32-bit signed integer divider: the inverse of the combinational Booth pair multiplier, sitting beside it in the ALU datapath. It takes a dividend and divisor, runs a one-bit-per-cycle restoring division on the operand magnitudes, applies sign correction, and returns quotient and remainder. The result is also packed as a 64-bit `{remainder, quotient}` word, the same shape as the multiplier product, for the HI/LO registers.

## Interface
- `WIDTH`, 32: operand width. Only 32 is verified.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `clr` input 1: synchronous active-high reset.
- `start` input 1: request a division. Sampled only in IDLE.
- `dividend` input 32: signed two's-complement dividend, sampled on the accepted `start` edge.
- `divisor` input 32: signed two's-complement divisor, sampled on the accepted `start` edge.
- `busy` output 1: high from the accepting edge until the edge that asserts `done`.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `quotient` output 32: signed quotient, truncated toward zero.
- `remainder` output 32: signed remainder; its sign follows the dividend.
- `result` output 64: `{remainder, quotient}`.
- `div_zero` output 1: divisor was zero. Registered with `done`.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, start=1:**
  - Latch `|dividend|` into the quotient shift register and `|divisor|`.
  - Latch `q_neg = sign(dividend)^sign(divisor)` and `r_neg = sign(dividend)`.
  - Clear the 33-bit partial remainder and set the iteration counter to 0.
  - `busy` goes to 1; go to CALC.
- **CALC, once per cycle:**
  - Shift `{partial_rem, qreg}` left by 1.
  - Trial subtract `partial_rem - |divisor|` (33-bit). If the result is non-negative, keep it and set `qreg[0]=1`. Otherwise restore and set `qreg[0]=0`.
  - Counter increments. After the 32nd iteration (counter 31) go to FIX.
- **FIX, one cycle:**
  - `quotient = q_neg ? -qreg : qreg`.
  - `remainder = r_neg ? -partial_rem[31:0] : partial_rem[31:0]`.
  - `done=1`, `busy=0`; go to IDLE.
- **Holding results:** `quotient`, `remainder`, `result` and `div_zero` hold until the next FIX or `clr`.
- **Arithmetic rules:**
  - Magnitudes are formed as unsigned 32-bit values, so `|-2^31| = 0x80000000`.
  - Negation is 32-bit two's-complement with wrap.
  - `-2^31 / -1` gives quotient 0x80000000, remainder 0 (overflow wraps, no flag).
- **Start while busy:** `start` during CALC or FIX is ignored and not queued.
- **Reset:** `clr` in any state returns to IDLE and zeroes `busy`, `done`, `quotient`, `remainder`, `result`, `div_zero` on that edge. An in-flight division is discarded. `clr` has priority over `start`.

## Timing
- **Reset values:** all outputs 0.
- **Latency:** with `start` sampled high at edge N, `busy`=1 after edge N, and `done`=1 and results valid after edge N+33 (34 edges).
- **Throughput:** one division per 34 cycles.
- **Back-to-back:** `start` may be high in the same cycle that `done` is high, because the FSM is already in IDLE. That request is accepted at the next edge.
- **done:** high for exactly one cycle; never high together with `busy`.

## Configuration
- `DIV_ZERO_TRAP_EN` **defined:**
  - A zero divisor in IDLE with `start` skips CALC and goes directly to FIX on the next edge.
  - `done` is valid after edge N+1 (2-cycle latency) with `div_zero=1`, `quotient=0xFFFFFFFF`, `remainder=dividend`.
- `DIV_ZERO_TRAP_EN` **undefined:**
  - `div_zero` is tied to 0.
  - A zero divisor runs the full 34-cycle algorithm, giving magnitude quotient 0xFFFFFFFF and magnitude remainder `|dividend|`, then normal sign correction. Example: 100/0 gives q=0xFFFFFFFF, r=100; -100/0 gives q=0x00000001, r=-100.

## Test plan
- **Positive:** 45/7 -> q=6, r=3, result=0x00000003_00000006, `done` exactly 34 edges after `start`.
- **Mixed signs:**
  - -7/2 -> q=-3 (0xFFFFFFFD), r=-1.
  - 7/-2 -> q=-3, r=1.
  - -12/-4 -> q=3, r=0.
- **Extremes:**
  - 0x80000000/-1 -> q=0x80000000, r=0.
  - 0x7FFFFFFF/1 -> q=0x7FFFFFFF, r=0.
  - 5/9 -> q=0, r=5.
- **Handshake:**
  - `start` pulsed at cycles 5, 10 and 33 of a running operation -> ignored, first result unchanged.
  - `start` held high through `done` -> second division accepted on the edge after the `done` cycle.
- **Reset mid-operation:** `clr` at iteration 15 -> next cycle shows `busy=0`, `done=0`, all outputs 0. A subsequent 100/10 gives q=10, r=0.
- **Divide by zero:** 100/0
  - With the macro: `done` at edge N+1, `div_zero=1`, q=0xFFFFFFFF, r=100.
  - Without the macro: `done` at N+33, `div_zero=0`, q=0xFFFFFFFF, r=100.
